// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared constants, types and helpers for the Ascon permutation engine
package ascon_pkg;

    localparam int STATE_W = 320;
    localparam int CTR_W   = 5;
    localparam int WORD_W  = 64;

    // First round constant for each supported round count; later rounds step down by RC_STEP
    localparam logic [7:0] RC_START_6  = 8'h96;
    localparam logic [7:0] RC_START_8  = 8'hB4;
    localparam logic [7:0] RC_START_12 = 8'hF0;
    localparam logic [7:0] RC_STEP     = 8'h0F;

    // Linear-layer rotate-right amounts, one pair per state word
    localparam int ROT_X0_A = 19;
    localparam int ROT_X0_B = 28;
    localparam int ROT_X1_A = 61;
    localparam int ROT_X1_B = 39;
    localparam int ROT_X2_A = 1;
    localparam int ROT_X2_B = 6;
    localparam int ROT_X3_A = 10;
    localparam int ROT_X3_B = 17;
    localparam int ROT_X4_A = 7;
    localparam int ROT_X4_B = 41;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } perm_state_t;

    // Only 6 and 8 are honoured; anything else (including 0) falls back to the full 12 rounds
    function automatic logic [CTR_W-1:0] eff_rounds(input logic [CTR_W-1:0] r);
        if ((r == CTR_W'(6)) || (r == CTR_W'(8))) begin
            return r;
        end
        return CTR_W'(12);
    endfunction

    // Round constant of the first round for an already-normalised round count
    function automatic logic [7:0] rc_start(input logic [CTR_W-1:0] eff);
        case (eff)
            CTR_W'(6): return RC_START_6;
            CTR_W'(8): return RC_START_8;
            default:   return RC_START_12;
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] rotr64(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    // Ascon linear diffusion of one word: x ^ rotr(x,a) ^ rotr(x,b)
    function automatic logic [WORD_W-1:0] lin64(input logic [WORD_W-1:0] x, input int a, input int b);
        return x ^ rotr64(x, a) ^ rotr64(x, b);
    endfunction

endpackage

// File: rtl/ascon_round.sv
// rtl/ascon_round.sv - one combinational Ascon round: constant addition, S-box layer, linear layer
module ascon_round
    import ascon_pkg::*;
(
    input  logic [STATE_W-1:0] i_state,
    input  logic [7:0]         i_rc,
    output logic [STATE_W-1:0] o_state
);

    logic [WORD_W-1:0] w_x0, w_x1, w_x2, w_x3, w_x4;
    logic [WORD_W-1:0] w_s0, w_s1, w_s2, w_s3, w_s4;
    logic [WORD_W-1:0] w_k0, w_k1, w_k2, w_k3, w_k4;
    logic [WORD_W-1:0] w_y0, w_y1, w_y2, w_y3, w_y4;

    // Split the state into words and add the round constant into the low byte of x2
    always_comb begin
        w_x0 = i_state[319:256];
        w_x1 = i_state[255:192];
        w_x2 = i_state[191:128] ^ {{(WORD_W-8){1'b0}}, i_rc};
        w_x3 = i_state[127:64];
        w_x4 = i_state[63:0];
    end

    // Bitsliced 5-bit S-box: input whitening, chi-like nonlinear step, output whitening
    always_comb begin
        w_s0 = w_x0 ^ w_x4;
        w_s1 = w_x1;
        w_s2 = w_x2 ^ w_x1;
        w_s3 = w_x3;
        w_s4 = w_x4 ^ w_x3;

        w_k0 = w_s0 ^ (~w_s1 & w_s2);
        w_k1 = w_s1 ^ (~w_s2 & w_s3);
        w_k2 = w_s2 ^ (~w_s3 & w_s4);
        w_k3 = w_s3 ^ (~w_s4 & w_s0);
        w_k4 = w_s4 ^ (~w_s0 & w_s1);

        w_y1 = w_k1 ^ w_k0;
        w_y0 = w_k0 ^ w_k4;
        w_y3 = w_k3 ^ w_k2;
        w_y2 = ~w_k2;
        w_y4 = w_k4;
    end

    // Per-word linear diffusion and reassembly in x0..x4 order
    always_comb begin
        o_state = {lin64(w_y0, ROT_X0_A, ROT_X0_B),
                   lin64(w_y1, ROT_X1_A, ROT_X1_B),
                   lin64(w_y2, ROT_X2_A, ROT_X2_B),
                   lin64(w_y3, ROT_X3_A, ROT_X3_B),
                   lin64(w_y4, ROT_X4_A, ROT_X4_B)};
    end

endmodule

// File: rtl/ascon_perm_ctrl.sv
// rtl/ascon_perm_ctrl.sv - iterative Ascon permutation engine, one round per clock, valid/ready in and out
module ascon_perm_ctrl
    import ascon_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] state_in,
    input  logic [CTR_W-1:0]   rounds_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] state_out,
    output logic [CTR_W-1:0]   ctr,
    output logic [CTR_W-1:0]   rounds,
    output logic [7:0]         rc
);

    perm_state_t        r_state;
    perm_state_t        w_state_nxt;
    logic [STATE_W-1:0] r_data;
    logic [CTR_W-1:0]   r_ctr;
    logic [CTR_W-1:0]   r_rounds;
    logic [7:0]         w_rc;
    logic [7:0]         w_rc_idx;
    logic               w_last_round;
    logic [STATE_W-1:0] w_round_out;

    assign w_last_round = (r_ctr == r_rounds);

    ascon_round u_round (
        .i_state (r_data),
        .i_rc    (w_rc),
        .o_state (w_round_out)
    );

    // FSM state register; reset abandons any in-flight permutation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake outputs; DONE always passes through IDLE before a new accept
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last_round) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Round constant from the 1-based counter; forced to zero whenever no round is being applied
    always_comb begin
        w_rc_idx = 8'(r_ctr) - 8'd1;
        w_rc     = 8'd0;
        if (r_state == RUN) begin
            w_rc = rc_start(r_rounds) - 8'(w_rc_idx * RC_STEP);
        end
    end

    // State word, round counter and round count: latch on accept, advance one round per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data   <= '0;
            r_ctr    <= '0;
            r_rounds <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data   <= state_in;
                        r_rounds <= eff_rounds(rounds_in);
                        r_ctr    <= CTR_W'(1);
                    end
                end
                RUN: begin
                    r_data <= w_round_out;
                    if (w_last_round) begin
                        r_ctr <= '0;
                    end else begin
                        r_ctr <= r_ctr + CTR_W'(1);
                    end
                end
                default: begin
                    r_ctr <= '0;
                end
            endcase
        end
    end

    assign state_out = r_data;
    assign ctr       = r_ctr;
    assign rounds    = r_rounds;
    assign rc        = w_rc;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// tb/tb_ascon_perm_ctrl.sv - directed self-checking bench for ascon_perm_ctrl
module tb_ascon_perm_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [319:0] state_in = '0;
    logic [4:0]   rounds_in = '0;
    logic         in_ready;
    logic         out_valid;
    logic [319:0] state_out;
    logic [4:0]   ctr;
    logic [4:0]   rounds;
    logic [7:0]   rc;

    int total = 0;
    int bad   = 0;

    logic [319:0] pat_a, pat_b, pat_c, pat_d, pat_e, rnd1, rnd2, held;

    ascon_perm_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .rounds_in (rounds_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .ctr       (ctr),
        .rounds    (rounds),
        .rc        (rc)
    );

    always #5 clk = ~clk;

    // Full 12-round constant list; shorter permutations use its tail
    function automatic logic [7:0] rc_hand(input int i);
        case (i)
            0:  return 8'hF0;
            1:  return 8'hE1;
            2:  return 8'hD2;
            3:  return 8'hC3;
            4:  return 8'hB4;
            5:  return 8'hA5;
            6:  return 8'h96;
            7:  return 8'h87;
            8:  return 8'h78;
            9:  return 8'h69;
            10: return 8'h5A;
            default: return 8'h4B;
        endcase
    endfunction

    // Ascon 5-bit S-box lookup table, x0 as the most significant input bit
    function automatic logic [4:0] sbox(input logic [4:0] v);
        case (v)
            5'd0:  return 5'h04; 5'd1:  return 5'h0b; 5'd2:  return 5'h1f; 5'd3:  return 5'h14;
            5'd4:  return 5'h1a; 5'd5:  return 5'h15; 5'd6:  return 5'h09; 5'd7:  return 5'h02;
            5'd8:  return 5'h1b; 5'd9:  return 5'h05; 5'd10: return 5'h08; 5'd11: return 5'h12;
            5'd12: return 5'h1d; 5'd13: return 5'h03; 5'd14: return 5'h06; 5'd15: return 5'h1c;
            5'd16: return 5'h1e; 5'd17: return 5'h13; 5'd18: return 5'h07; 5'd19: return 5'h0e;
            5'd20: return 5'h00; 5'd21: return 5'h0d; 5'd22: return 5'h11; 5'd23: return 5'h18;
            5'd24: return 5'h10; 5'd25: return 5'h0c; 5'd26: return 5'h01; 5'd27: return 5'h19;
            5'd28: return 5'h16; 5'd29: return 5'h0a; 5'd30: return 5'h0f; default: return 5'h17;
        endcase
    endfunction

    // Reference permutation: column-wise table S-box and bit-indexed rotations
    function automatic logic [319:0] perm_model(input logic [319:0] s, input int r);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  v;
        logic [4:0]  o;
        int ra [5];
        int rb [5];
        ra = '{19, 61, 1, 10, 7};
        rb = '{28, 39, 6, 17, 41};
        for (int w = 0; w < 5; w++) x[w] = s[319 - 64*w -: 64];
        for (int k = 0; k < r; k++) begin
            x[2][7:0] = x[2][7:0] ^ rc_hand(12 - r + k);
            for (int j = 0; j < 64; j++) begin
                v = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
                o = sbox(v);
                y[0][j] = o[4];
                y[1][j] = o[3];
                y[2][j] = o[2];
                y[3][j] = o[1];
                y[4][j] = o[0];
            end
            for (int w = 0; w < 5; w++)
                for (int j = 0; j < 64; j++)
                    x[w][j] = y[w][j] ^ y[w][(j + ra[w]) % 64] ^ y[w][(j + rb[w]) % 64];
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge in IDLE; returns at the negedge of the first DONE cycle
    task automatic run_req(input logic [319:0] st, input logic [4:0] rin, input int er, input string tag);
        logic [319:0] exp;
        exp = perm_model(st, er);
        chk($sformatf("%s in_ready_idle", tag), in_ready, 1);
        state_in  = st;
        rounds_in = rin;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        state_in  = ~st;
        rounds_in = 5'd6;
        chk($sformatf("%s in_ready_run", tag), in_ready, 0);
        chk($sformatf("%s rounds", tag), rounds, er);
        for (int k = 1; k <= er; k++) begin
            chk($sformatf("%s ctr_%0d", tag, k), ctr, k);
            chk($sformatf("%s rc_%0d", tag, k), rc, rc_hand(12 - er + k - 1));
            chk($sformatf("%s out_valid_run_%0d", tag, k), out_valid, 0);
            @(negedge clk);
        end
        chk($sformatf("%s out_valid_done", tag), out_valid, 1);
        chk($sformatf("%s ctr_done", tag), ctr, 0);
        chk($sformatf("%s rc_done", tag), rc, 0);
        chk($sformatf("%s state_out", tag), state_out, exp);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk($sformatf("%s out_valid_after_hs", tag), out_valid, 0);
        chk($sformatf("%s in_ready_after_hs", tag), in_ready, 1);
    endtask

    initial begin
        pat_a = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f1e2d3c4b5a6978,
                 64'h8796a5b4c3d2e1f0, 64'hdeadbeefcafef00d};
        pat_b = {64'hffffffffffffffff, 64'h0000000000000000, 64'haaaaaaaaaaaaaaaa,
                 64'h5555555555555555, 64'h8000000000000001};
        pat_c = {64'h80400c0600000000, 64'h1122334455667788, 64'h0000000000000001,
                 64'h0000000000000000, 64'hf0f0f0f00f0f0f0f};
        pat_d = {64'h243f6a8885a308d3, 64'h13198a2e03707344, 64'ha4093822299f31d0,
                 64'h082efa98ec4e6c89, 64'h452821e638d01377};
        pat_e = {64'hbe5466cf34e90c6c, 64'hc0ac29b7c97c50dd, 64'h3f84d5b5b5470917,
                 64'h9216d5d98979fb1b, 64'hd1310ba698dfb5ac};
        for (int i = 0; i < 10; i++) begin
            rnd1[32*i +: 32] = $urandom();
            rnd2[32*i +: 32] = $urandom();
        end

        // Reset values while held in reset and just after release
        repeat (2) @(negedge clk);
        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst ctr", ctr, 0);
        chk("rst rounds", rounds, 0);
        chk("rst rc", rc, 0);
        chk("rst state_out", state_out, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst in_ready", in_ready, 1);
        chk("post_rst out_valid", out_valid, 0);

        // 12, 6 and 8 rounds with their constant sequences and latencies
        run_req('0, 5'd12, 12, "r12_zero");
        handshake("r12_zero");
        run_req(pat_a, 5'd6, 6, "r6");
        handshake("r6");
        run_req(pat_b, 5'd8, 8, "r8");
        handshake("r8");

        // Out-of-range round requests fall back to 12
        run_req(pat_c, 5'd7, 12, "r7");
        handshake("r7");
        run_req(pat_d, 5'd0, 12, "r0");

        // Backpressure in DONE with a new request offered
        held = perm_model(pat_d, 12);
        for (int i = 0; i < 20; i++) begin
            in_valid  = (i >= 5 && i < 8);
            state_in  = pat_e;
            rounds_in = 5'd6;
            @(negedge clk);
            chk($sformatf("hold out_valid_%0d", i), out_valid, 1);
            chk($sformatf("hold state_out_%0d", i), state_out, held);
            chk($sformatf("hold in_ready_%0d", i), in_ready, 0);
            chk($sformatf("hold ctr_%0d", i), ctr, 0);
        end
        in_valid = 1'b0;
        handshake("hold");
        @(negedge clk);
        chk("hold no_accept", ctr, 0);

        // Asynchronous reset at ctr=4 of a 12-round run
        state_in  = pat_e;
        rounds_in = 5'd12;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst ctr_before", ctr, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst ctr", ctr, 0);
        chk("arst rc", rc, 0);
        chk("arst out_valid", out_valid, 0);
        chk("arst in_ready", in_ready, 1);
        chk("arst rounds", rounds, 0);
        chk("arst state_out", state_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_req(pat_e, 5'd12, 12, "after_rst");
        handshake("after_rst");

        // Back-to-back with out_ready tied high
        out_ready = 1'b1;
        run_req(rnd1, 5'd12, 12, "b2b_1");
        @(negedge clk);
        chk("b2b idle_gap in_ready", in_ready, 1);
        chk("b2b idle_gap out_valid", out_valid, 0);
        run_req(rnd2, 5'd6, 6, "b2b_2");
        @(negedge clk);
        out_ready = 1'b0;
        chk("b2b end in_ready", in_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
